// File: rtl/settle_driver_pkg.sv
// Shared FSM encoding, default sizing constants and a sizing helper for settle_driver_n.
package settle_driver_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2,
        ST_GUARD  = 2'd3
    } drv_state_e;

    localparam int DEF_STATE_W = 7;
    localparam int DEF_SETTLE  = 7;
    localparam int DEF_HOLD    = 31;
    localparam int DEF_GUARD   = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/driver_timer.sv
// Clearable up-counter with terminal-count compare, shared by settle, hold and guard phases.
module driver_timer
    import settle_driver_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/settle_driver_n.sv
// Settle-then-enable driver: waits for a stable state bus, then emits a fixed-length enable pulse.
// Optional post-pulse low guard phase enabled by defining SETTLE_DRIVER_GUARD_EN.
module settle_driver_n
    import settle_driver_pkg::*;
#(
    parameter int STATE_W       = DEF_STATE_W,
    parameter int SETTLE_CYCLES = DEF_SETTLE,
    parameter int HOLD_CYCLES   = DEF_HOLD,
    parameter int RETRIGGER     = 1,
    parameter int GUARD_CYCLES  = DEF_GUARD
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] state,
    output logic               enable,
    output logic [STATE_W-1:0] state_out,
    output logic               busy
);

    localparam int CNT_W = $clog2(max3(SETTLE_CYCLES, HOLD_CYCLES, GUARD_CYCLES) + 1);
    localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(HOLD_CYCLES - 1);
`ifdef SETTLE_DRIVER_GUARD_EN
    localparam logic [CNT_W-1:0] GUARD_TC  = CNT_W'(GUARD_CYCLES - 1);
`endif

    drv_state_e         fsm;
    logic [STATE_W-1:0] s_q;
    logic               change;
    logic               rearm;
    logic               pending;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   term;
    logic               tc;
    logic               clr;

    assign change = (state != s_q);
    assign rearm  = change && (RETRIGGER != 0);

    always_comb begin
        term = '0;
        case (fsm)
            ST_SETTLE: term = SETTLE_TC;
            ST_HOLD:   term = HOLD_TC;
`ifdef SETTLE_DRIVER_GUARD_EN
            ST_GUARD:  term = GUARD_TC;
`endif
            default:   term = '0;
        endcase
    end

    // Counter restarts on every phase entry and on any change while settling.
    assign clr = (fsm == ST_IDLE) || ((fsm == ST_SETTLE) && change) || tc;

    driver_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (clr),
        .term  (term),
        .cnt   (cnt),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        s_q <= state;
        if (reset) begin
            fsm       <= ST_IDLE;
            enable    <= 1'b0;
            busy      <= 1'b0;
            state_out <= '0;
            pending   <= 1'b0;
        end else begin
            case (fsm)
                ST_IDLE: begin
                    if (change) begin
                        fsm  <= ST_SETTLE;
                        busy <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!change && tc) begin
                        fsm       <= ST_HOLD;
                        enable    <= 1'b1;
                        state_out <= state;
                    end
                end
                ST_HOLD: begin
                    if (tc) begin
                        enable <= 1'b0;
`ifdef SETTLE_DRIVER_GUARD_EN
                        fsm     <= ST_GUARD;
                        pending <= pending || rearm;
`else
                        pending <= 1'b0;
                        if (pending || rearm) begin
                            fsm <= ST_SETTLE;
                        end else begin
                            fsm  <= ST_IDLE;
                            busy <= 1'b0;
                        end
`endif
                    end else begin
                        pending <= pending || rearm;
                    end
                end
`ifdef SETTLE_DRIVER_GUARD_EN
                ST_GUARD: begin
                    if (tc) begin
                        pending <= 1'b0;
                        if (pending || rearm) begin
                            fsm <= ST_SETTLE;
                        end else begin
                            fsm  <= ST_IDLE;
                            busy <= 1'b0;
                        end
                    end else begin
                        pending <= pending || rearm;
                    end
                end
`endif
                default: begin
                    fsm     <= ST_IDLE;
                    enable  <= 1'b0;
                    busy    <= 1'b0;
                    pending <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_settle_driver_n.sv
// Scoreboard bench for settle_driver_n: one instance with RETRIGGER=1 and one with RETRIGGER=0.
module tb_settle_driver_n;

    typedef struct {
        int         start;
        int         len;
        logic [6:0] so;
    } pulse_t;

    typedef struct {
        int         at;
        int         k;
        logic       en;
        logic       bsy;
        logic [6:0] so;
        string      name;
    } lvl_t;

`ifdef SETTLE_DRIVER_GUARD_EN
    localparam int GG = 4;
`else
    localparam int GG = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] state;
    logic       en1, en0, busy1, busy0;
    logic [6:0] so1, so0;

    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    bit     done = 1'b0;
    pulse_t pq0[$];
    pulse_t pq1[$];
    lvl_t   lq[$];

    settle_driver_n #(.RETRIGGER(1)) dut (
        .clk(clk), .reset(reset), .state(state),
        .enable(en1), .state_out(so1), .busy(busy1)
    );

    settle_driver_n #(.RETRIGGER(0)) dut_nr (
        .clk(clk), .reset(reset), .state(state),
        .enable(en0), .state_out(so0), .busy(busy0)
    );

    always #1 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
        end
    endfunction

    // Monitor: measures pulses and pops expectations, plus timed level checks.
    bit         prev_en[2];
    int         st[2];
    logic [6:0] so_cap[2];
    always @(negedge clk) begin
        if (!done) begin
            for (int k = 0; k < 2; k++) begin
                logic       en_now;
                logic [6:0] so_now;
                pulse_t     e;
                bit         have;
                en_now = (k == 1) ? en1 : en0;
                so_now = (k == 1) ? so1 : so0;
                if (en_now && !prev_en[k]) begin
                    st[k]     = cyc;
                    so_cap[k] = so_now;
                end
                if (!en_now && prev_en[k]) begin
                    have = 1'b0;
                    if (k == 1 && pq1.size() > 0) begin e = pq1.pop_front(); have = 1'b1; end
                    if (k == 0 && pq0.size() > 0) begin e = pq0.pop_front(); have = 1'b1; end
                    if (have) begin
                        chk($sformatf("pulse_start_k%0d", k), st[k], e.start);
                        chk($sformatf("pulse_len_k%0d", k), cyc - st[k], e.len);
                        chk($sformatf("pulse_state_out_k%0d", k), int'(so_cap[k]), int'(e.so));
                    end else begin
                        chk($sformatf("unexpected_pulse_k%0d_start", k), st[k], -1);
                    end
                end
                prev_en[k] = en_now;
            end
            while (lq.size() > 0 && lq[0].at <= cyc) begin
                lvl_t l;
                l = lq.pop_front();
                chk({l.name, "_enable"}, int'((l.k == 1) ? en1 : en0), int'(l.en));
                chk({l.name, "_busy"}, int'((l.k == 1) ? busy1 : busy0), int'(l.bsy));
                chk({l.name, "_state_out"}, int'((l.k == 1) ? so1 : so0), int'(l.so));
            end
        end else begin
            chk("leftover_pulses_k1", pq1.size(), 0);
            chk("leftover_pulses_k0", pq0.size(), 0);
            chk("leftover_level_checks", lq.size(), 0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    task automatic lvl(input int at, input int k, input logic e, input logic b,
                       input logic [6:0] so, input string name);
        lvl_t l;
        l.at = at; l.k = k; l.en = e; l.bsy = b; l.so = so; l.name = name;
        lq.push_back(l);
    endtask

    task automatic lvl2(input int at, input logic e, input logic b,
                        input logic [6:0] so, input string name);
        lvl(at, 0, e, b, so, {name, "_k0"});
        lvl(at, 1, e, b, so, {name, "_k1"});
    endtask

    task automatic exp_pulse(input int k, input int start, input int len, input logic [6:0] so);
        pulse_t p;
        p.start = start; p.len = len; p.so = so;
        if (k == 1) pq1.push_back(p);
        else        pq0.push_back(p);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy1 && !busy0 && pq0.size() == 0 && pq1.size() == 0 && lq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            $display("FAIL wait_idle timeout at cycle %0d: busy1=%0b busy0=%0b pending_exp=%0d/%0d, expected idle",
                     cyc, busy1, busy0, pq1.size(), pq0.size());
            $fatal(1);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int c, s;
        reset = 1'b1;
        state = 7'd0;
        repeat (3) @(negedge clk);
        lvl2(cyc + 1, 1'b0, 1'b0, 7'd0, "reset_state");
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Single change then hold.
        c = cyc; state = 7'd1; s = c + 8;
        exp_pulse(1, s, 31, 7'd1);
        exp_pulse(0, s, 31, 7'd1);
        lvl2(s + 5, 1'b1, 1'b1, 7'd1, "t1_hold");
        lvl2(s + 31 + GG, 1'b0, 1'b0, 7'd1, "t1_busy_low");
        wait_idle();

        // Ten changes three clocks apart.
        for (int i = 0; i < 10; i++) begin
            state = 7'(2 + i);
            if (i < 9) repeat (3) @(negedge clk);
        end
        c = cyc; s = c + 8;
        lvl2(c + 7, 1'b0, 1'b1, 7'd1, "t2_no_early");
        exp_pulse(1, s, 31, 7'd11);
        exp_pulse(0, s, 31, 7'd11);
        wait_idle();

        // Change at hold cycle 10.
        c = cyc; state = 7'd20; s = c + 8;
        repeat (18) @(negedge clk);
        state = 7'd21;
        exp_pulse(1, s, 31, 7'd20);
        exp_pulse(1, s + 38 + GG, 31, 7'd21);
        exp_pulse(0, s, 31, 7'd20);
        lvl(s + 34 + GG, 1, 1'b0, 1'b1, 7'd20, "t3_gap_k1");
        lvl(s + 41 + GG, 0, 1'b0, 1'b0, 7'd20, "t3_nr_idle_k0");
        wait_idle();

        // Change on the final hold edge.
        c = cyc; state = 7'd30; s = c + 8;
        repeat (38) @(negedge clk);
        state = 7'd31;
        exp_pulse(1, s, 31, 7'd30);
        exp_pulse(1, s + 38 + GG, 31, 7'd31);
        exp_pulse(0, s, 31, 7'd30);
        wait_idle();

        // Reset at hold cycle 15.
        c = cyc; state = 7'd40; s = c + 8;
        exp_pulse(1, s, 16, 7'd40);
        exp_pulse(0, s, 16, 7'd40);
        repeat (23) @(negedge clk);
        lvl2(s + 16, 1'b0, 1'b0, 7'd0, "t5_reset");
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        lvl2(cyc + 1, 1'b0, 1'b0, 7'd0, "t5_quiet");
        wait_idle();

`ifdef SETTLE_DRIVER_GUARD_EN
        // Change during guard.
        c = cyc; state = 7'd50; s = c + 8;
        repeat (40) @(negedge clk);
        state = 7'd51;
        exp_pulse(1, s, 31, 7'd50);
        exp_pulse(1, s + 42, 31, 7'd51);
        exp_pulse(0, s, 31, 7'd50);
        wait_idle();
`endif

        done = 1'b1;
    end

    initial begin
        #40000;
        $display("FAIL watchdog at cycle %0d: simulation did not complete, expected finish", cyc);
        $fatal(1);
    end

endmodule
